// File: rtl/lcd_bus_arbiter_pkg.sv
// Shared types and default timing for the LCD bus arbiter.
// States walk IDLE -> OWN -> STROBE -> HOLD, then back to OWN or IDLE.
package lcd_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      OWN    = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } lcd_state_e;

   localparam int EN_HIGH_DEF = 2;
   localparam int EN_HOLD_DEF = 1;
   localparam int TIMEOUT_DEF = 255;

   localparam logic LCD_RW_WRITE = 1'b0;
   localparam logic LCD_RW_IDLE  = 1'b1;

endpackage

// File: rtl/lcd_bus_arbiter_if.sv
// Writer-side bus of the LCD arbiter: one request/byte lane per writer.
// A byte moves when wr_valid[i] and wr_ready[i] are both high at a clock edge;
// wr_valid may be held across cycles, data must stay stable until accepted,
// and req[i] stays high for the whole locked transaction.
interface lcd_bus_arbiter_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]   req;
   logic [NUM_REQ-1:0]   wr_valid;
   logic [8*NUM_REQ-1:0] wr_data;
   logic [NUM_REQ-1:0]   wr_rs;
   logic [NUM_REQ-1:0]   wr_rst;
   logic [NUM_REQ-1:0]   wr_last;
   logic [NUM_REQ-1:0]   wr_ready;
   logic [NUM_REQ-1:0]   grant;

   modport master (
      output req, wr_valid, wr_data, wr_rs, wr_rst, wr_last,
      input  wr_ready, grant
   );

   modport slave (
      input  req, wr_valid, wr_data, wr_rs, wr_rst, wr_last,
      output wr_ready, grant
   );
endinterface

// File: rtl/lcd_bus_arbiter_rr.sv
// Combinational round-robin picker: searches from ptr+1 upward, wrapping,
// so the requester at ptr (the last one served) has the lowest priority.
module rr_arbiter #(
   parameter  int NUM_REQ = 2,
   localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PW-1:0]      ptr,
   output logic [NUM_REQ-1:0] winner
);

   always_comb begin
      int idx;
      winner = '0;
      idx    = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = (int'(ptr) + i) % NUM_REQ;
         if (req[idx] && (winner == '0)) begin
            winner[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Shares one character-LCD bus between NUM_REQ writers with locked grants
// and generates the EN strobe timing for every accepted byte.
module lcd_bus_arbiter
   import lcd_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int EN_HIGH = EN_HIGH_DEF,
   parameter int EN_HOLD = EN_HOLD_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             system_clk,
   input  logic             rst,
   lcd_bus_arbiter_if.slave bus,
   output logic             busy,
   output logic [7:0]       LCD_DATA,
   output logic             LCD_RS,
   output logic             LCD_RW,
   output logic             LCD_EN,
   output logic             LCD_RST,
   output lcd_state_e       state_dbg
);

   localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CMAX = (EN_HIGH > EN_HOLD) ? EN_HIGH : EN_HOLD;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   lcd_state_e         state_q, state_n;
   logic [CW-1:0]      cnt_q, cnt_n;
   logic [WD_W-1:0]    wd_q, wd_n;
   logic [NUM_REQ-1:0] grant_q, grant_n;
   logic [NUM_REQ-1:0] ready_q, ready_n;
   logic [PW-1:0]      ptr_q, ptr_n;
   logic [7:0]         data_q, data_n;
   logic               rs_q, rs_n, rw_q, rw_n, en_q, en_n, lrst_q, lrst_n;
   logic               last_q, last_n;

   logic [NUM_REQ-1:0] pick;
   logic [PW-1:0]      owner;
   logic [7:0]         sel_data;
   logic               sel_rs, sel_rst, sel_last, sel_req, accept, wd_expire;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req    (bus.req),
      .ptr    (ptr_q),
      .winner (pick)
   );

   // Steer the current owner's lane onto a single set of select signals.
   always_comb begin
      owner    = '0;
      sel_data = '0;
      sel_rs   = 1'b0;
      sel_rst  = 1'b0;
      sel_last = 1'b0;
      sel_req  = 1'b0;
      accept   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i]) begin
            owner    = PW'(i);
            sel_data = bus.wr_data[i*8 +: 8];
            sel_rs   = bus.wr_rs[i];
            sel_rst  = bus.wr_rst[i];
            sel_last = bus.wr_last[i];
            sel_req  = bus.req[i];
            accept   = bus.wr_valid[i] & ready_q[i];
         end
      end
   end

   assign wd_expire = (TIMEOUT != 0) && (wd_q == WD_W'(TIMEOUT - 1));

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      wd_n    = wd_q;
      grant_n = grant_q;
      ready_n = '0;
      ptr_n   = ptr_q;
      data_n  = data_q;
      rs_n    = rs_q;
      rw_n    = rw_q;
      en_n    = en_q;
      lrst_n  = lrst_q;
      last_n  = last_q;
      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               grant_n = pick;
               ready_n = pick;
               wd_n    = '0;
               state_n = OWN;
            end
         end
         OWN: begin
            if (accept) begin
               data_n  = sel_data;
               rs_n    = sel_rs;
               lrst_n  = sel_rst;
               last_n  = sel_last;
               rw_n    = LCD_RW_WRITE;
               en_n    = 1'b1;
               cnt_n   = '0;
               wd_n    = '0;
               state_n = STROBE;
            end else if (!sel_req || wd_expire) begin
               // Abort or watchdog: drop the grant without touching the LCD pins.
               grant_n = '0;
               ptr_n   = owner;
               wd_n    = '0;
               state_n = IDLE;
            end else begin
               ready_n = grant_q;
               wd_n    = wd_q + WD_W'(1);
            end
         end
         STROBE: begin
            if (cnt_q == CW'(EN_HIGH - 1)) begin
               en_n    = 1'b0;
               cnt_n   = '0;
               state_n = HOLD;
            end else begin
               cnt_n = cnt_q + CW'(1);
            end
         end
         HOLD: begin
            if (cnt_q == CW'(EN_HOLD - 1)) begin
               cnt_n = '0;
               if (last_q || !sel_req) begin
                  grant_n = '0;
                  ptr_n   = owner;
                  rw_n    = LCD_RW_IDLE;
                  lrst_n  = 1'b0;
                  state_n = IDLE;
               end else begin
                  ready_n = grant_q;
                  state_n = OWN;
               end
            end else begin
               cnt_n = cnt_q + CW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge system_clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wd_q    <= '0;
         grant_q <= '0;
         ready_q <= '0;
         ptr_q   <= '0;
         data_q  <= '0;
         rs_q    <= 1'b0;
         rw_q    <= LCD_RW_IDLE;
         en_q    <= 1'b0;
         lrst_q  <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         wd_q    <= wd_n;
         grant_q <= grant_n;
         ready_q <= ready_n;
         ptr_q   <= ptr_n;
         data_q  <= data_n;
         rs_q    <= rs_n;
         rw_q    <= rw_n;
         en_q    <= en_n;
         lrst_q  <= lrst_n;
         last_q  <= last_n;
      end
   end

   assign bus.grant    = grant_q;
   assign bus.wr_ready = ready_q;
   assign busy         = (state_q != IDLE);
   assign LCD_DATA     = data_q;
   assign LCD_RS       = rs_q;
   assign LCD_RW       = rw_q;
   assign LCD_EN       = en_q;
   assign LCD_RST      = lrst_q;
   assign state_dbg    = state_q;

endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
- Shares the single character-LCD bus (LCD_DATA/RS/RW/EN/RST) between NUM_REQ independent writers, e.g. the page/title writer and the score writer.
- Each writer streams bytes through a valid/ready handshake. A grant is held as a locked transaction until that writer's last byte.
- The block generates the EN strobe timing itself, so writers never drive LCD pins directly.
- Sits between the game-level text/score sources and the LCD pins.

Parameters:
- NUM_REQ, 2: number of requesters (2..4).
- EN_HIGH, 2: cycles LCD_EN stays high per byte (>=1).
- EN_HOLD, 1: cycles DATA/RS/RST are held after the EN falling edge (>=1).
- TIMEOUT, 255: idle-grant watchdog in cycles. 0 disables it.

Ports:
- system_clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  per-requester bus request; held high for the whole transaction.
- wr_valid  in  NUM_REQ  byte valid.
- wr_data  in  8*NUM_REQ  byte for requester i, in bits [8i+7:8i].
- wr_rs  in  NUM_REQ  RS value for the byte (1 = data, 0 = command).
- wr_rst  in  NUM_REQ  LCD_RST value driven during the byte (page clear/reset).
- wr_last  in  NUM_REQ  byte is the last of the transaction.
- wr_ready  out  NUM_REQ  byte accepted when wr_valid[i] and wr_ready[i] are both high.
- grant  out  NUM_REQ  one-hot current owner.
- busy  out  1  any grant active or strobe in flight.
- LCD_DATA  out  8  LCD data bus.
- LCD_RS  out  1  LCD register select.
- LCD_RW  out  1  LCD read/write; 0 during writes.
- LCD_EN  out  1  LCD enable; the byte is latched on its falling edge.
- LCD_RST  out  1  LCD reset/clear line.

Behaviour:
- Reset (rst=0, async): state=IDLE, grant=0, wr_ready=0, busy=0, LCD_DATA=0, LCD_RS=0, LCD_RW=1, LCD_EN=0, LCD_RST=0, rr pointer=0, watchdog=0.
- State IDLE:
  - No req: stay in IDLE.
  - Otherwise pick the winner round-robin, starting at (ptr+1) mod NUM_REQ. Register grant one-hot and go to OWN.
  - Arbitration latency: req high at cycle t gives grant high at t+1.
- State OWN:
  - wr_ready[g]=1 and all other wr_ready bits are 0. wr_ready is registered, so it is high only in OWN.
  - On accept, capture data/rs/rst/last into the LCD_* registers, set LCD_RW=0 and LCD_EN=1 next cycle, go to STROBE.
- State STROBE:
  - LCD_EN stays high for exactly EN_HIGH cycles, then falls to 0. Go to HOLD.
  - LCD_DATA/RS/RST remain stable throughout.
- State HOLD:
  - Lasts EN_HOLD cycles with LCD_EN=0 and data still stable.
  - If the captured last=1: release. grant=0, ptr=g, LCD_RW=1, LCD_RST=0, go to IDLE.
  - Otherwise return to OWN.
  - LCD_DATA keeps its last value after release.
- Throughput: one byte per 1+EN_HIGH+EN_HOLD cycles (4 at defaults) with wr_valid held high.
- Early drop: req[g] falling while in OWN with no accept releases the grant (abort) and goes to IDLE next cycle, ptr=g. A req drop during STROBE/HOLD has no effect until that byte completes; release happens at end of HOLD.
- Watchdog:
  - Counts cycles in OWN without an accept and clears on every accept.
  - On reaching TIMEOUT, force release exactly as an abort.
- Simultaneous requests: round-robin only; a requester that was just served has lowest priority next.
- Requests from non-owners are ignored while a grant is held; no preemption.
- req and wr_valid without a grant: no effect, no error.
- Reset mid-strobe: all outputs return to reset values immediately (async). The partially written byte is lost.
- busy = (state != IDLE).

Decomposition:
- Package lcd_pkg holds:
  - the state enum (IDLE, OWN, STROBE, HOLD);
  - default timing constants (EN_HIGH, EN_HOLD, TIMEOUT);
  - LCD_RW_WRITE/LCD_RW_IDLE constants.
- Sub-module rr_arbiter(NUM_REQ): combinational round-robin picker from req and ptr, outputting a one-hot winner. The pointer register stays in the parent.

Test Plan:
- Single byte: req[0]=1 with valid, data=8'h33, rs=1, last=1 → grant[0] at t+1. LCD_EN high for exactly 2 cycles with LCD_DATA=8'h33 and LCD_RS=1, then falls. Grant released after 1 hold cycle. LCD_RW returns to 1.
- Burst: requester 1 streams 10 bytes ASCII "0000001234", last on the 10th → 10 EN pulses spaced 4 cycles apart, the bytes in order, exactly 10 accepts.
- Contention: req=2'b11 from IDLE with ptr=0 → requester 1 is served first. After its last byte, requester 0 is granted. No EN pulse overlaps a grant change.
- Abort and watchdog:
  - req[0] dropped in OWN → grant=0 next cycle, no EN pulse.
  - With TIMEOUT=8, req held with no valid → forced release after 8 cycles.
- Page clear: byte with wr_rst=1 → LCD_RST=1 for the whole strobe and hold window, then LCD_RST=0 after release.
- Async reset: rst low during the STROBE high phase → LCD_EN=0, LCD_RW=1, grant=0 immediately without a clock edge. Normal arbitration resumes after reset deasserts.
